// File: rtl/acc_sequencer.sv
// acc_sequencer: multi-cycle control sequencer for the accumulator mini-processor.
// Fetches 8-bit instructions over a req/ack handshake, decodes the opcode in
// ir[7:4] and issues one-cycle strobes to the register file, ALU commit and
// divider. It also keeps the program counter, the halt state and a sticky
// divider-timeout error.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   run                   start request, sampled only in IDLE
//   imem_req/ack/data     instruction fetch handshake; imem_addr always equals pc
//   rf_addr, rf_rd, rf_wr register-file address (ir[3:0]) and read/write strobes
//   alu_en, alu_op        ACC/flag commit strobe and the latched instruction
//   div_start, div_done   divider start pulse and result-valid input
//   flag_c                carry/borrow flag, sampled by JC in DECODE
//   pc, hlt, err, busy    program counter, halted, divider timeout, active
module acc_sequencer #(
    parameter int unsigned DIV_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       imem_req,
    input  logic       imem_ack,
    input  logic [7:0] imem_data,
    output logic [7:0] imem_addr,
    output logic [3:0] rf_addr,
    output logic       rf_rd,
    output logic       rf_wr,
    output logic       alu_en,
    output logic [7:0] alu_op,
    output logic       div_start,
    input  logic       div_done,
    input  logic       flag_c,
    output logic [7:0] pc,
    output logic       hlt,
    output logic       err,
    output logic       busy
);

    localparam int unsigned CW = $clog2(DIV_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_DIVWAIT,
        S_HALT
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    pc_q, pc_nx;
    logic [7:0]    ir_q, ir_nx;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic          err_q, err_nx;

    logic [3:0]    op;
    logic [3:0]    arg;
    logic [7:0]    target;
    logic [7:0]    pc_inc;

    assign op     = ir_q[7:4];
    assign arg    = ir_q[3:0];
    assign target = {4'h0, ir_q[3:0]};
    assign pc_inc = pc_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc_q  <= '0;
            ir_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            ir_q  <= ir_nx;
            cnt_q <= cnt_nx;
            err_q <= err_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc_q;
        ir_nx     = ir_q;
        cnt_nx    = cnt_q;
        err_nx    = err_q;
        imem_req  = 1'b0;
        rf_rd     = 1'b0;
        rf_wr     = 1'b0;
        alu_en    = 1'b0;
        div_start = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) state_nx = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_nx    = imem_data;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    4'hF: state_nx = S_HALT;
                    4'h0: state_nx = S_EXEC;
                    4'h8: begin
                        pc_nx    = flag_c ? target : pc_inc;
                        state_nx = S_FETCH;
                    end
                    4'hB: begin
                        pc_nx    = target;
                        state_nx = S_FETCH;
                    end
                    4'hA: begin
                        rf_wr    = 1'b1;
                        pc_nx    = pc_inc;
                        state_nx = S_FETCH;
                    end
                    4'hC, 4'hD, 4'hE: begin
                        pc_nx    = pc_inc;
                        state_nx = S_FETCH;
                    end
                    default: state_nx = S_READ;
                endcase
            end
            S_READ: begin
                rf_rd    = 1'b1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (op == 4'h4) begin
                    div_start = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = S_DIVWAIT;
                end else begin
                    // Only opcodes 0-3, 5-7 and 9 reach EXEC; opcode 0 commits
                    // for sub-ops 1-7 only.
                    alu_en   = (op != 4'h0) || (arg != 4'h0 && !arg[3]);
                    pc_nx    = pc_inc;
                    state_nx = S_FETCH;
                end
            end
            S_DIVWAIT: begin
                // cnt_q holds the DIVWAIT cycles already spent, so the
                // DIV_TIMEOUT-th cycle without div_done is the last one;
                // div_done in that same cycle still completes normally.
                if (div_done) begin
                    alu_en   = 1'b1;
                    pc_nx    = pc_inc;
                    state_nx = S_FETCH;
                end else if (cnt_q == CW'(DIV_TIMEOUT - 1)) begin
                    err_nx   = 1'b1;
                    state_nx = S_HALT;
                end else begin
                    cnt_nx = cnt_q + 1'b1;
                end
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign rf_addr   = ir_q[3:0];
    assign alu_op    = ir_q;
    assign err       = err_q;
    assign hlt       = (state == S_HALT);
    assign busy      = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_acc_sequencer.sv
// Testbench for acc_sequencer: an instruction-level model expands each
// instruction into the per-cycle inputs and expected outputs; one process
// drives the inputs and another compares every output every cycle.
module tb_acc_sequencer;

    localparam int unsigned TO = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, imem_ack, div_done, flag_c;
    logic [7:0] imem_data;
    logic       imem_req, rf_rd, rf_wr, alu_en, div_start, hlt, err, busy;
    logic [7:0] imem_addr, alu_op, pc;
    logic [3:0] rf_addr;

    acc_sequencer #(.DIV_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .imem_addr(imem_addr), .rf_addr(rf_addr), .rf_rd(rf_rd), .rf_wr(rf_wr),
        .alu_en(alu_en), .alu_op(alu_op), .div_start(div_start),
        .div_done(div_done), .flag_c(flag_c), .pc(pc), .hlt(hlt), .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       run, ack, flag, done;
        logic [7:0] data;
        logic       req, rd, wr, alu, ds, hlt, err, busy;
        logic [7:0] pc, ir;
    } rec_t;

    rec_t script[$];
    rec_t cur;
    bit   cur_valid = 0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // instruction-level model state
    logic [7:0] m_pc, m_ir;
    logic       m_err;

    // monitors used by the literal checks
    int cyc = 0, first_fetch = -1, alu_cyc = -1;
    int rd_cnt = 0, wr_cnt = 0, alu_cnt = 0, ds_cnt = 0, req_len = 0;
    bit fetch_done = 0;
    logic [3:0] rd_addr_seen, wr_addr_seen;
    logic [7:0] alu_op_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic emit(input logic run_i, input logic ack_i, input logic [7:0] data_i,
                        input logic flag_i, input logic done_i,
                        input logic req_e, input logic rd_e, input logic wr_e,
                        input logic alu_e, input logic ds_e, input logic hlt_e,
                        input logic busy_e);
        rec_t r;
        r.run = run_i; r.ack = ack_i; r.data = data_i; r.flag = flag_i; r.done = done_i;
        r.req = req_e; r.rd = rd_e; r.wr = wr_e; r.alu = alu_e; r.ds = ds_e;
        r.hlt = hlt_e; r.busy = busy_e;
        r.pc = m_pc; r.ir = m_ir; r.err = m_err;
        script.push_back(r);
    endtask

    // one idle cycle with run low, then the run request
    task automatic gen_start();
        emit(1'b0, rb(), 8'($urandom), rb(), rb(), 0, 0, 0, 0, 0, 0, 0);
        emit(1'b1, rb(), 8'($urandom), rb(), rb(), 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic gen_halt(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            emit(rb(), rb(), 8'($urandom), rb(), rb(), 0, 0, 0, 0, 0, 1, 0);
    endtask

    // divd: DIVWAIT cycle (1-based) in which div_done is raised; 0 = never
    task automatic gen_instr(input logic [7:0] instr, input int unsigned waits,
                             input logic flag, input int unsigned divd,
                             output bit halted);
        logic [3:0] op, arg;
        logic       a, d;
        halted = 0;
        for (int unsigned i = 0; i < waits; i++)
            emit(rb(), 1'b0, 8'($urandom), rb(), rb(), 1, 0, 0, 0, 0, 0, 1);
        emit(rb(), 1'b1, instr, rb(), rb(), 1, 0, 0, 0, 0, 0, 1);
        m_ir = instr;
        op   = instr[7:4];
        arg  = instr[3:0];
        emit(rb(), rb(), 8'($urandom), flag, rb(), 0, 0, (op == 4'hA), 0, 0, 0, 1);
        case (op)
            4'hF: begin halted = 1; return; end
            4'h8: begin m_pc = flag ? {4'h0, arg} : m_pc + 8'd1; return; end
            4'hB: begin m_pc = {4'h0, arg}; return; end
            4'hA, 4'hC, 4'hD, 4'hE: begin m_pc = m_pc + 8'd1; return; end
            4'h0: ;
            default: emit(rb(), rb(), 8'($urandom), rb(), rb(), 0, 1, 0, 0, 0, 0, 1);
        endcase
        if (op == 4'h4) begin
            emit(rb(), rb(), 8'($urandom), rb(), rb(), 0, 0, 0, 0, 1, 0, 1);
            for (int unsigned k = 1; k <= TO; k++) begin
                d = (k == divd);
                emit(rb(), rb(), 8'($urandom), rb(), d, 0, 0, 0, d, 0, 0, 1);
                if (d) begin m_pc = m_pc + 8'd1; return; end
            end
            m_err  = 1'b1;
            halted = 1;
        end else begin
            a = (op != 4'h0) || (arg >= 4'd1 && arg <= 4'd7);
            emit(rb(), rb(), 8'($urandom), rb(), rb(), 0, 0, 0, a, 0, 0, 1);
            m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic play(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cur = script.pop_front();
            run = cur.run; imem_ack = cur.ack; imem_data = cur.data;
            flag_c = cur.flag; div_done = cur.done;
            cur_valid = 1;
        end
        @(negedge clk);
        #1 cur_valid = 0;
    endtask

    task automatic play_all();
        play(script.size());
    endtask

    task automatic clr_mon();
        cyc = 0; first_fetch = -1; alu_cyc = -1;
        rd_cnt = 0; wr_cnt = 0; alu_cnt = 0; ds_cnt = 0; req_len = 0; fetch_done = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run = 0; imem_ack = 0; imem_data = 0; flag_c = 0; div_done = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = '0; m_ir = '0; m_err = 1'b0;
        script.delete();
        clr_mon();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " imem_req"},  32'(imem_req), 0);
        check({tag, " rf_rd"},     32'(rf_rd), 0);
        check({tag, " rf_wr"},     32'(rf_wr), 0);
        check({tag, " alu_en"},    32'(alu_en), 0);
        check({tag, " div_start"}, 32'(div_start), 0);
        check({tag, " pc"},        32'(pc), 0);
        check({tag, " alu_op"},    32'(alu_op), 0);
        check({tag, " hlt"},       32'(hlt), 0);
        check({tag, " err"},       32'(err), 0);
        check({tag, " busy"},      32'(busy), 0);
    endtask

    // cycle-by-cycle compare against the model trace
    always @(negedge clk) begin
        if (cur_valid) begin
            check("imem_req",  32'(imem_req),  32'(cur.req));
            check("imem_addr", 32'(imem_addr), 32'(cur.pc));
            check("pc",        32'(pc),        32'(cur.pc));
            check("rf_addr",   32'(rf_addr),   32'(cur.ir[3:0]));
            check("alu_op",    32'(alu_op),    32'(cur.ir));
            check("rf_rd",     32'(rf_rd),     32'(cur.rd));
            check("rf_wr",     32'(rf_wr),     32'(cur.wr));
            check("alu_en",    32'(alu_en),    32'(cur.alu));
            check("div_start", 32'(div_start), 32'(cur.ds));
            check("hlt",       32'(hlt),       32'(cur.hlt));
            check("err",       32'(err),       32'(cur.err));
            check("busy",      32'(busy),      32'(cur.busy));
        end
    end

    always @(negedge clk) begin
        if (cur_valid) begin
            if (imem_req && first_fetch < 0) first_fetch = cyc;
            if (first_fetch >= 0 && !fetch_done) begin
                if (imem_req) req_len++;
                else fetch_done = 1;
            end
            if (rf_rd) begin rd_cnt++; rd_addr_seen = rf_addr; end
            if (rf_wr) begin wr_cnt++; wr_addr_seen = rf_addr; end
            if (alu_en) begin alu_cnt++; alu_op_seen = alu_op; if (alu_cyc < 0) alu_cyc = cyc; end
            if (div_start) ds_cnt++;
            cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit h;
        logic [7:0] ins;
        int unsigned w, dd, r;

        // reset state
        rst_n = 1'b0;
        run = 0; imem_ack = 0; imem_data = 0; flag_c = 0; div_done = 0;
        #23;
        check_reset_vals("reset");

        // program 0x15, 0xF0 with immediate acks
        do_reset();
        gen_start();
        gen_instr(8'h15, 0, rb(), 0, h);
        gen_instr(8'hF0, 0, rb(), 0, h);
        gen_halt(4);
        play_all();
        check("p1 rd_cnt", 32'(rd_cnt), 1);
        check("p1 rd_addr", 32'(rd_addr_seen), 5);
        check("p1 alu_cnt", 32'(alu_cnt), 1);
        check("p1 alu_op", 32'(alu_op_seen), 32'h15);
        check("p1 alu_cycle", 32'(alu_cyc - first_fetch), 3);
        check("p1 req_len", 32'(req_len), 1);
        check("p1 hlt", 32'(hlt), 1);
        check("p1 pc", 32'(pc), 1);

        // same program, first ack delayed 3 cycles
        do_reset();
        gen_start();
        gen_instr(8'h15, 3, rb(), 0, h);
        gen_instr(8'hF0, 0, rb(), 0, h);
        gen_halt(4);
        play_all();
        check("p2 req_len", 32'(req_len), 4);
        check("p2 alu_cycle", 32'(alu_cyc - first_fetch), 6);
        check("p2 pc", 32'(pc), 1);

        // JMP 0xB3, JC 0x87 not taken, JC 0x87 taken
        do_reset();
        gen_start();
        gen_instr(8'hB3, 0, rb(), 0, h);
        gen_instr(8'h87, 1, 1'b0, 0, h);
        gen_instr(8'h87, 0, 1'b1, 0, h);
        gen_instr(8'hF0, 0, rb(), 0, h);
        gen_halt(3);
        play_all();
        check("jmp pc", 32'(pc), 7);
        check("jmp rd_cnt", 32'(rd_cnt), 0);
        check("jmp alu_cnt", 32'(alu_cnt), 0);

        // divide completing after 6 DIVWAIT cycles
        do_reset();
        gen_start();
        gen_instr(8'h42, 0, rb(), 6, h);
        gen_instr(8'hF0, 0, rb(), 0, h);
        gen_halt(3);
        play_all();
        check("div pc", 32'(pc), 1);
        check("div err", 32'(err), 0);
        check("div ds_cnt", 32'(ds_cnt), 1);
        check("div alu_cnt", 32'(alu_cnt), 1);

        // divide timing out
        do_reset();
        gen_start();
        gen_instr(8'h42, 0, rb(), 0, h);
        gen_halt(4);
        play_all();
        check("to err", 32'(err), 1);
        check("to hlt", 32'(hlt), 1);
        check("to pc", 32'(pc), 0);

        // STORE at pc=FF wraps pc to 0
        do_reset();
        gen_start();
        for (int i = 0; i < 255; i++) gen_instr(8'hC0, 0, rb(), 0, h);
        gen_instr(8'hA9, 0, rb(), 0, h);
        gen_instr(8'hF0, 0, rb(), 0, h);
        gen_halt(3);
        play_all();
        check("st wr_cnt", 32'(wr_cnt), 1);
        check("st wr_addr", 32'(wr_addr_seen), 9);
        check("st rd_cnt", 32'(rd_cnt), 0);
        check("st pc", 32'(pc), 0);

        // asynchronous reset in the middle of DIVWAIT
        do_reset();
        gen_start();
        gen_instr(8'h42, 0, rb(), 0, h);
        play(11);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("async");
        run = 0; imem_ack = 1; imem_data = 8'h15; div_done = 0;
        #2 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post-reset busy", 32'(busy), 0);
            check("post-reset imem_req", 32'(imem_req), 0);
        end

        // randomized program
        do_reset();
        gen_start();
        for (int i = 0; i < 200; i++) begin
            ins = 8'($urandom);
            if (ins[7:4] == 4'hF) ins[7:4] = 4'h0;
            w  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            r  = $urandom_range(0, 9);
            dd = (r == 0) ? TO : $urandom_range(1, 7);
            gen_instr(ins, w, rb(), dd, h);
        end
        gen_instr(8'hF0, 0, rb(), 0, h);
        gen_halt(3);
        play_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
